ccff_loader: RTL and testbench

Configuration-chain driver that sits directly upstream of the fabric tiles' `ccff_head` inputs. It accepts bitstream words over a valid/ready stream and serialises them, LSB first, onto the configuration flip-flop chain, one bit per enabled `prog_clk` cycle. It produces a clock-enable that the top level uses to gate the chain's clock, so the chain shifts only on cycles carrying a valid bit. It holds the I/O isolation (`isol_n`) asserted until a full chain load completes.

---
 rtl/ccff_loader_pkg.sv | 15 +
 rtl/ccff_crc16.sv | 27 ++
 rtl/ccff_loader.sv | 150 +++++++++++++++
 tb/tb_ccff_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
// Holds the loader FSM state type and the readback CRC constants.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    SHIFT,
    DONE
  } ccff_ld_state_t;

  localparam logic [15:0] CCFF_CRC_POLY = 16'h1021;
  localparam logic [15:0] CCFF_CRC_SEED = 16'hFFFF;

endpackage

// File: rtl/ccff_crc16.sv
// Serial-in CRC-16-CCITT with enable and synchronous clear to the seed.
// Ports: clk, rst, clr, en, din in; crc[15:0] out.
module ccff_crc16
  import ccff_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic fb;

  assign fb = crc[15] ^ din;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= CCFF_CRC_SEED;
    end else if (en) begin
      crc <= {crc[14:0], 1'b0}
           ^ (fb ? CCFF_CRC_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/ccff_loader.sv
// Serialises valid/ready bitstream words LSB first onto the config chain.
// Ports: prog_clk, prog_reset, start, cfg_data/valid/ready, ccff_head,
// ccff_clk_en, ccff_tail, busy, done, isol_n. Readback CRC output
// (readback_crc) exists only when CCFF_LOADER_READBACK_EN is defined.
module ccff_loader
  import ccff_loader_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int CHAIN_LEN = 1024
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              isol_n
`ifdef CCFF_LOADER_READBACK_EN
  ,
  output logic [15:0]       readback_crc
`endif
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam int BL_W  = $clog2(CHAIN_LEN + 1);

  ccff_ld_state_t    state_q;
  ccff_ld_state_t    state_d;
  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] hold;
  logic              hold_vld;
  logic              en_q;
  logic              isol_q;
  logic [IDX_W-1:0]  bit_idx;
  logic [BL_W-1:0]   bits_left;
  logic              accept;
  logic              last_bit;
  logic              word_end;

  assign accept   = cfg_valid && cfg_ready;
  assign last_bit = en_q && (bits_left == BL_W'(1));
  assign word_end = en_q && (bit_idx == IDX_W'(DATA_W - 1));

  assign ccff_head   = sr[0];
  assign ccff_clk_en = en_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign isol_n      = isol_q;

  always_comb begin
    state_d   = state_q;
    cfg_ready = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = FILL;
      FILL: begin
        cfg_ready = 1'b1;
        if (cfg_valid) state_d = SHIFT;
      end
      SHIFT: begin
        cfg_ready = !hold_vld;
        if (last_bit) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A word accepted while the shift register is exhausted (or stalled)
  // goes straight into sr so a late word costs no extra bubble.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q   <= IDLE;
      sr        <= '0;
      hold      <= '0;
      hold_vld  <= 1'b0;
      en_q      <= 1'b0;
      isol_q    <= 1'b0;
      bit_idx   <= '0;
      bits_left <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            bits_left <= BL_W'(CHAIN_LEN);
            bit_idx   <= '0;
            isol_q    <= 1'b0;
          end
        end
        FILL: begin
          if (accept) begin
            sr      <= cfg_data;
            en_q    <= 1'b1;
            bit_idx <= '0;
          end
        end
        SHIFT: begin
          if (en_q) begin
            sr        <= sr >> 1;
            bits_left <= bits_left - BL_W'(1);
            bit_idx   <= word_end ? '0
                       : bit_idx + IDX_W'(1);
            if (last_bit) begin
              en_q     <= 1'b0;
              hold_vld <= 1'b0;
              isol_q   <= 1'b1;
            end else if (word_end) begin
              if (hold_vld) begin
                sr       <= hold;
                hold_vld <= 1'b0;
              end else if (accept) begin
                sr <= cfg_data;
              end else begin
                en_q <= 1'b0;
              end
            end else if (accept) begin
              hold     <= cfg_data;
              hold_vld <= 1'b1;
            end
          end else if (accept) begin
            sr   <= cfg_data;
            en_q <= 1'b1;
          end
        end
        DONE: hold_vld <= 1'b0;
        default: ;
      endcase
    end
  end

`ifdef CCFF_LOADER_READBACK_EN
  ccff_crc16 u_crc (
    .clk (prog_clk),
    .rst (prog_reset),
    .clr ((state_q == IDLE) && start),
    .en  (en_q),
    .din (ccff_tail),
    .crc (readback_crc)
  );
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_loader.sv
// Directed bench for ccff_loader with DATA_W=8, CHAIN_LEN=20.
// Vector table for full loads plus hand-written reset/readback cases.
module tb_ccff_loader;

  localparam int DW = 8;
  localparam int CL = 20;

  typedef struct {
    logic [3:0][7:0] w;
    int              nw;
    int              gap;
    int              restart;
    logic [CL-1:0]   bits;
    int              done_cyc;
    int              n_gap;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic          head;
  logic          en;
  logic          tail;
  logic          busy;
  logic          done;
  logic          isol_n;
`ifdef CCFF_LOADER_READBACK_EN
  logic [15:0]   readback_crc;
  logic [15:0]   crc_at_done;
`endif

  logic [CL-1:0] chain = '0;
  logic [CL-1:0] got;
  int            n_en;
  int            n_gap;
  int            n_acc;
  int            cyc;
  int            done_at;
  logic          isol_at_done;
  logic          mon_clr = 1'b0;
  logic          feed_abort;
  int            n_chk = 0;
  int            n_pass = 0;
  vec_t          vecs[5];

  ccff_loader #(.DATA_W(DW), .CHAIN_LEN(CL)) dut (
    .prog_clk    (clk),
    .prog_reset  (rst),
    .start       (start),
    .cfg_data    (cfg_data),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .ccff_head   (head),
    .ccff_clk_en (en),
    .ccff_tail   (tail),
    .busy        (busy),
    .done        (done),
    .isol_n      (isol_n)
`ifdef CCFF_LOADER_READBACK_EN
    ,
    .readback_crc(readback_crc)
`endif
  );

  always #5 clk = ~clk;

  // Model of the fabric chain: shifts only on enabled edges.
  always @(posedge clk) if (en) chain <= {chain[CL-2:0], head};
  assign tail = chain[CL-1];

  always @(negedge clk) begin
    if (mon_clr) begin
      cyc     <= 0;
      n_en    <= 0;
      n_gap   <= 0;
      n_acc   <= 0;
      done_at <= -1;
      got     <= '0;
    end else begin
      cyc <= cyc + 1;
      if (cfg_valid && cfg_ready) n_acc <= n_acc + 1;
      if (en) begin
        if (n_en < CL) got[n_en] <= head;
        n_en <= n_en + 1;
      end else if (busy && !done && n_en > 0 && n_en < CL) begin
        n_gap <= n_gap + 1;
      end
      if (done && done_at < 0) begin
        done_at      <= cyc + 1;
        isol_at_done <= isol_n;
`ifdef CCFF_LOADER_READBACK_EN
        crc_at_done  <= readback_crc;
`endif
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      n_pass++;
  endtask

  function automatic logic [15:0] crc_of(input logic [CL-1:0] b);
    logic [15:0] c = 16'hFFFF;
    for (int i = 0; i < CL; i++) begin
      logic fb = c[15] ^ b[i];
      c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  task automatic feed(input logic [3:0][7:0] w, input int nw,
                      input int gap);
    for (int i = 0; i < nw && !feed_abort; i++) begin
      bit ok = 0;
      if (i == 1 && gap > 0) begin
        for (int k = 0; k < 100 && !en; k++) @(negedge clk);
        for (int k = 0; k < 100 && en; k++) @(negedge clk);
        repeat (gap - 1) @(posedge clk);
        #1;
      end
      cfg_data  = w[i];
      cfg_valid = 1'b1;
      for (int k = 0; k < 100 && !feed_abort; k++) begin
        @(negedge clk);
        if (cfg_ready) begin ok = 1; break; end
      end
      if (!ok) break;
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
    end
    cfg_valid = 1'b0;
  endtask

  // Pulses start; on return E0 (the edge sampling start) has passed.
  task automatic kick();
    @(posedge clk);
    #1;
    start   = 1'b1;
    mon_clr = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    mon_clr = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 200 && done_at < 0; k++) @(posedge clk);
    #1;
    chk("done_seen", 32'(done_at >= 0), 32'd1);
  endtask

  task automatic run_case(input int v);
    vec_t t = vecs[v];
    feed_abort = 1'b0;
    kick();
    fork
      feed(t.w, t.nw, t.gap);
      begin
        @(negedge clk);
        chk($sformatf("v%0d_isol_low", v), 32'(isol_n), 32'd0);
        if (t.restart > 0) begin
          for (int k = 0; k < 100 && n_en < t.restart; k++)
            @(posedge clk);
          #1;
          start = 1'b1;
          @(negedge clk);
          chk($sformatf("v%0d_busy_restart", v), 32'(busy), 32'd1);
          @(posedge clk);
          #1;
          start = 1'b0;
        end
        wait_done();
      end
    join
    @(posedge clk);
    #1;
    chk($sformatf("v%0d_bits", v), 32'(got), 32'(t.bits));
    chk($sformatf("v%0d_en_cnt", v), 32'(n_en), 32'(CL));
    chk($sformatf("v%0d_gap", v), 32'(n_gap), 32'(t.n_gap));
    chk($sformatf("v%0d_done_cyc", v), 32'(done_at + 1),
        32'(t.done_cyc));
    chk($sformatf("v%0d_isol_done", v), 32'(isol_at_done), 32'd1);
    chk($sformatf("v%0d_acc", v), 32'(n_acc), 32'(t.nw));
    chk($sformatf("v%0d_hold_idle", v), 32'(dut.hold_vld), 32'd0);
    chk($sformatf("v%0d_busy_idle", v), 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{w: {8'h00, 8'h0F, 8'h3C, 8'hA5}, nw: 3, gap: 0,
                restart: 0, bits: 20'hF3CA5, done_cyc: 23, n_gap: 0};
    vecs[1] = '{w: {8'h00, 8'h56, 8'h34, 8'h12}, nw: 3, gap: 0,
                restart: 0, bits: 20'h63412, done_cyc: 23, n_gap: 0};
    vecs[2] = '{w: {8'h00, 8'h0F, 8'h3C, 8'hA5}, nw: 3, gap: 5,
                restart: 0, bits: 20'hF3CA5, done_cyc: 28, n_gap: 5};
    vecs[3] = '{w: {8'h00, 8'h0F, 8'h3C, 8'hA5}, nw: 3, gap: 0,
                restart: 10, bits: 20'hF3CA5, done_cyc: 23, n_gap: 0};
    vecs[4] = '{w: {8'h78, 8'h56, 8'h34, 8'h12}, nw: 4, gap: 0,
                restart: 0, bits: 20'h63412, done_cyc: 23, n_gap: 0};

    rst        = 1'b1;
    start      = 1'b0;
    cfg_data   = '0;
    cfg_valid  = 1'b0;
    feed_abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_head", 32'(head), 32'd0);
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_isol", 32'(isol_n), 32'd0);
`ifdef CCFF_LOADER_READBACK_EN
    chk("rst_crc", 32'(readback_crc), 32'hFFFF);
`endif

    for (int v = 0; v < 5; v++) run_case(v);

    // Reset after 7 shifted bits aborts the load.
    feed_abort = 1'b0;
    kick();
    fork
      feed(vecs[0].w, 3, 0);
      begin
        for (int k = 0; k < 100 && n_en < 7; k++) @(posedge clk);
        #1;
        rst        = 1'b1;
        feed_abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_ready", 32'(cfg_ready), 32'd0);
        chk("mid_rst_en", 32'(en), 32'd0);
        chk("mid_rst_head", 32'(head), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_isol", 32'(isol_n), 32'd0);
        chk("mid_rst_hold", 32'(dut.hold_vld), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    run_case(0);

`ifdef CCFF_LOADER_READBACK_EN
    run_case(0);
    chk("readback_crc", 32'(crc_at_done), 32'(crc_of(20'hF3CA5)));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
